// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the iterative multiply/divide unit.
//   md_op_e    : funct3 encodings of the M-extension ops
//   md_state_e : unit FSM states
//   is_div / is_rem / is_signed_a / is_signed_b : op decode helpers
package muldiv_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned TAG_W_DEFAULT = 5;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_e;

    function automatic logic is_div(input md_op_e op);
        return (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
    endfunction

    function automatic logic is_rem(input md_op_e op);
        return (op inside {OP_REM, OP_REMU});
    endfunction

    function automatic logic is_signed_a(input md_op_e op);
        return (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    endfunction

    function automatic logic is_signed_b(input md_op_e op);
        return (op inside {OP_MULH, OP_DIV, OP_REM});
    endfunction

endpackage

// File: rtl/md_iter_step.sv
// One iteration of the magnitude datapath (combinational).
//   is_div  : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_hi  : mul: partial product high half / div: partial remainder
//   acc_lo  : mul: multiplier bits still to consume / div: dividend bits, quotient shifted in
//   opm     : mul: multiplicand magnitude / div: divisor magnitude
//   nxt_hi, nxt_lo : accumulator after this step
module md_iter_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc_hi,
    input  logic [XLEN-1:0] acc_lo,
    input  logic [XLEN-1:0] opm,
    output logic [XLEN-1:0] nxt_hi,
    output logic [XLEN-1:0] nxt_lo
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    always_comb begin
        // Multiply: add multiplicand when the current multiplier LSB is set, then shift right.
        sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opm} : (XLEN+1)'(0));
        // Divide: bring the next dividend bit into the remainder and trial-subtract.
        // The remainder stays below the divisor, so one extra bit is enough for the sign.
        rem_sh = {acc_hi, acc_lo[XLEN-1]};
        diff   = rem_sh - {1'b0, opm};
        nxt_hi = sum[XLEN:1];
        nxt_lo = {sum[0], acc_lo[XLEN-1:1]};
        if (is_div) begin
            if (!diff[XLEN]) begin
                nxt_hi = diff[XLEN-1:0];
                nxt_lo = {acc_lo[XLEN-2:0], 1'b1};
            end else begin
                nxt_hi = rem_sh[XLEN-1:0];
                nxt_lo = {acc_lo[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit for the EX stage.
// Ports:
//   clk, rst (sync, active-low), flush (kill op in flight)
//   in_valid/in_ready, in_funct3, in_opa, in_opb, in_tag : op request
//   out_valid/out_ready, out_result, out_tag             : result, held until taken
//   busy                                                 : unit not idle
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned TAG_W = TAG_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_opa,
    input  logic [XLEN-1:0]  in_opb,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int unsigned     CNT_W    = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    md_state_e        state;
    logic [CNT_W-1:0] counter;
    md_op_e           op_q;
    logic [TAG_W-1:0] tag_q;
    logic             neg_a_q;
    logic             neg_b_q;
    logic [XLEN-1:0]  acc_hi;
    logic [XLEN-1:0]  acc_lo;
    logic [XLEN-1:0]  opm_q;

    md_op_e           in_op;
    logic             a_neg;
    logic             b_neg;
    logic [XLEN-1:0]  mag_a;
    logic [XLEN-1:0]  mag_b;
    logic             div_zero;
    logic             div_ovf;
    logic [XLEN-1:0]  spec_res;
    logic [XLEN-1:0]  step_hi;
    logic [XLEN-1:0]  step_lo;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]  quo_fix;
    logic [XLEN-1:0]  rem_fix;
    logic [XLEN-1:0]  fix_res;

    assign in_ready = (state == IDLE) & ~flush;

    // Request decode: signs, magnitudes and the divide special cases.
    // Negating MIN_NEG yields 2^(XLEN-1), which is its correct unsigned magnitude.
    always_comb begin
        in_op    = md_op_e'(in_funct3);
        a_neg    = is_signed_a(in_op) & in_opa[XLEN-1];
        b_neg    = is_signed_b(in_op) & in_opb[XLEN-1];
        mag_a    = a_neg ? (~in_opa + XLEN'(1)) : in_opa;
        mag_b    = b_neg ? (~in_opb + XLEN'(1)) : in_opb;
        div_zero = is_div(in_op) & (in_opb == '0);
        div_ovf  = (in_op inside {OP_DIV, OP_REM}) & (in_opa == MIN_NEG) & (in_opb == ALL_ONES);
        spec_res = is_rem(in_op) ? '0 : MIN_NEG;
        if (div_zero) begin
            spec_res = is_rem(in_op) ? in_opa : ALL_ONES;
        end
    end

    md_iter_step #(.XLEN(XLEN)) u_step (
        .is_div (is_div(op_q)),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo),
        .opm    (opm_q),
        .nxt_hi (step_hi),
        .nxt_lo (step_lo)
    );

    // Sign correction and result selection applied in FIX.
    always_comb begin
        prod_fix = {acc_hi, acc_lo};
        if (neg_a_q ^ neg_b_q) begin
            prod_fix = ~{acc_hi, acc_lo} + (2*XLEN)'(1);
        end
        quo_fix = (neg_a_q ^ neg_b_q) ? (~acc_lo + XLEN'(1)) : acc_lo;
        rem_fix = neg_a_q ? (~acc_hi + XLEN'(1)) : acc_hi;
        fix_res = prod_fix[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:          fix_res = prod_fix[XLEN-1:0];
            OP_DIV, OP_DIVU: fix_res = quo_fix;
            OP_REM, OP_REMU: fix_res = rem_fix;
            default:         fix_res = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    // Unit FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            counter    <= '0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            op_q       <= OP_MUL;
            tag_q      <= '0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            opm_q      <= '0;
        end else if (flush) begin
            state     <= IDLE;
            counter   <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q    <= in_op;
                        tag_q   <= in_tag;
                        neg_a_q <= a_neg;
                        neg_b_q <= b_neg;
                        counter <= '0;
                        busy    <= 1'b1;
                        acc_hi  <= '0;
                        // Divide shifts the dividend out of acc_lo; multiply consumes the multiplier there.
                        acc_lo  <= is_div(in_op) ? mag_a : mag_b;
                        opm_q   <= is_div(in_op) ? mag_b : mag_a;
                        if (div_zero | div_ovf) begin
                            state      <= DONE;
                            out_valid  <= 1'b1;
                            out_result <= spec_res;
                            out_tag    <= in_tag;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    if (counter == CNT_W'(XLEN-1)) begin
                        state   <= FIX;
                        counter <= '0;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                FIX: begin
                    state      <= DONE;
                    out_valid  <= 1'b1;
                    out_result <= fix_res;
                    out_tag    <= tag_q;
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit (XLEN=32): scoreboard of expected results.
module tb_ex_muldiv_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 5;
    localparam int          LAT_ITER = 33;  // edges from accept to out_valid (T+34)
    localparam int          LAT_SPEC = 0;   // special case: out_valid in cycle T+1

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_funct3;
    logic [XLEN-1:0]  in_opa;
    logic [XLEN-1:0]  in_opb;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  res;
        int               lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    ex_muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_funct3  (in_funct3),
        .in_opa     (in_opa),
        .in_opb     (in_opb),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference M-extension semantics.
    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa64;
        logic signed [63:0] sb64;
        logic signed [63:0] ub64;
        logic [63:0]        p;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        ub64 = {32'b0, b};
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa64 * sb64; return p[63:32]; end
            3'd2: begin p = sa64 * ub64; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return $signed(a) / $signed(b);
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return LAT_SPEC;
        return LAT_ITER;
    endfunction

    // Present one op at a negedge, accept on the next posedge; push its expectation.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] t, input logic [31:0] exp_res, input int exp_lat,
                         output int acc_cyc);
        exp_t e;
        @(negedge clk);
        in_valid  = 1'b1;
        in_funct3 = f;
        in_opa    = a;
        in_opb    = b;
        in_tag    = t;
        #1;
        check("in_ready_at_issue", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        e.tag = t;
        e.res = exp_res;
        e.lat = exp_lat;
        sb.push_back(e);
    endtask

    // Wait for out_valid, compare with scoreboard head, optionally stall, then take it.
    task automatic wait_result(input int acc_cyc, input int hold);
        exp_t e;
        bit   got = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        e = sb.pop_front();
        if (!got) begin
            check("out_valid_timeout", 64'd0, 64'd1);
            return;
        end
        check("latency", 64'(cyc - acc_cyc), 64'(e.lat));
        check("result",  64'(out_result), 64'(e.res));
        check("tag",     64'(out_tag), 64'(e.tag));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid",  64'(out_valid), 64'd1);
            check("hold_result", 64'(out_result), 64'(e.res));
            check("hold_tag",    64'(out_tag), 64'(e.tag));
            check("hold_no_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("idle_after_take", 64'(in_ready), 64'd1);
        check("valid_after_take", 64'(out_valid), 64'd0);
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    initial begin
        vec_t vecs[12];
        int   acc;
        bit   seen;
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_funct3 = '0; in_opa = '0; in_opb = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid",  64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_tag",    64'(out_tag), 64'd0);
        check("rst_busy",       64'(busy), 64'd0);
        rst = 1'b1;

        vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_ITER};
        vecs[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, LAT_ITER};
        vecs[2]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_ITER};
        vecs[3]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_ITER};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, LAT_ITER};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, LAT_ITER};
        vecs[6]  = '{3'b101, 32'd100,        32'd7,         32'd14,        LAT_ITER};
        vecs[7]  = '{3'b111, 32'd100,        32'd7,         32'd2,         LAT_ITER};
        vecs[8]  = '{3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, LAT_SPEC};
        vecs[9]  = '{3'b110, 32'd5,          32'd0,         32'd5,         LAT_SPEC};
        vecs[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, LAT_SPEC};
        vecs[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         LAT_SPEC};

        // Directed ops, back-to-back; DIVU result is held 10 cycles before being taken.
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].f, vecs[i].a, vecs[i].b, TAG_W'(i + 1), vecs[i].res, vecs[i].lat, acc);
            wait_result(acc, (i == 6) ? 10 : 0);
        end

        // Random ops against the reference model.
        for (int i = 0; i < 10; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(0, 9));
                1:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: rb = $urandom;
            endcase
            issue(rf, ra, rb, TAG_W'(i + 16), ref_md(rf, ra, rb), ref_lat(rf, ra, rb), acc);
            wait_result(acc, 0);
        end

        // Flush in BUSY: IDLE one cycle later, the op's result never appears.
        issue(3'b100, 32'd1000, 32'd3, 5'd30, 32'd333, LAT_ITER, acc);
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        check("flush_busy",     64'(busy), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_valid", 64'(seen), 64'd0);

        // flush together with in_valid: not accepted.
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1;
        in_funct3 = 3'b000; in_opa = 32'd2; in_opb = 32'd3; in_tag = 5'd7;
        #1;
        check("flush_blocks_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_no_accept", 64'(busy), 64'd0);

        // Reset during BUSY, then a fresh op.
        issue(3'b000, 32'd7, 32'd9, 5'd9, 32'd63, LAT_ITER, acc);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        check("midrst_out_valid",  64'(out_valid), 64'd0);
        check("midrst_out_result", 64'(out_result), 64'd0);
        check("midrst_out_tag",    64'(out_tag), 64'd0);
        check("midrst_busy",       64'(busy), 64'd0);
        issue(3'b011, 32'd3, 32'd5, 5'd11, 32'd0, LAT_ITER, acc);
        wait_result(acc, 0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
